// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter.
//   DATA_W      : width of the nibble carried in each frame
//   FRAME_BITS  : serial bits per frame (start, 4 data, parity, stop)
//   S_*         : 3-bit FSM state encoding
package parity_pkg;

  localparam int DATA_W     = 4;
  localparam int FRAME_BITS = 7;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter for the frame transmitter.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   clr  : hold the count at zero (used while the line is idle)
//   tick : high during the last cycle of a bit period (count == CLKS_PER_BIT-1)
// The count wraps to zero by itself after each tick, so every bit change
// starts a fresh period without a separate clear from the FSM.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (clr || tick) begin
      cnt_nxt = '0;
    end
  end

  // tick is registered from the next count so it lines up with cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= (LAST == '0);
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serializer for a nibble plus its even-parity bit.
// Frame on tx_out: start(0), a, b, c, d, parity, stop(1); each bit held
// CLKS_PER_BIT cycles. The line idles high.
//   clk, rst  : clock and synchronous active-high reset
//   in_valid  : upstream offers data/parity
//   in_ready  : high exactly in IDLE (combinational from state)
//   data      : nibble, data[3] sent first
//   parity    : parity bit from the generator, sent as-is
//   tx_out    : serial line (registered)
//   busy      : frame in progress (registered)
//   done      : pulse in the last cycle of the stop bit
//   par_err   : parity mismatch of the most recently accepted frame
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data,
  input  logic              parity,
  output logic              tx_out,
  output logic              busy,
  output logic              done,
  output logic              par_err
);

  function automatic logic parity_mismatch(input logic [DATA_W-1:0] d, input logic p);
    return p ^ (^d);
  endfunction

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [1:0]        bit_idx;
  logic [1:0]        bit_idx_nxt;
  logic [DATA_W:0]   shreg;
  logic [DATA_W:0]   shreg_nxt;
  logic              tick;
  logic              accept;
  logic              tx_nxt;
  logic              busy_nxt;

  // The counter is held at zero in IDLE so the start bit gets a full period.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .clr (state == S_IDLE),
    .tick(tick)
  );

  // State register, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_idx <= '0;
      par_err <= 1'b0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      tx_out  <= tx_nxt;
      busy    <= busy_nxt;
      if (accept) begin
        par_err <= parity_mismatch(data, parity);
      end
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  // Next-state logic. shreg holds {a,b,c,d,parity}; shifting left once per
  // data bit leaves the parity bit at the top for the PARITY slot.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt   = S_START;
          bit_idx_nxt = '0;
          shreg_nxt   = {data, parity};
        end
      end
      S_START: begin
        if (tick) begin
          state_nxt   = S_DATA;
          bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_nxt   = {shreg[DATA_W-1:0], 1'b1};
          bit_idx_nxt = bit_idx + 2'd1;
          if (bit_idx == 2'd3) begin
            state_nxt = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic. tx_out/busy are computed from the next state so that the
  // registered line shows the start bit in the cycle right after the accept.
  always_comb begin
    in_ready = (state == S_IDLE);
    accept   = in_valid && in_ready;
    busy_nxt = (state_nxt != S_IDLE);
    tx_nxt   = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shreg_nxt[DATA_W];
      S_PARITY: tx_nxt = shreg_nxt[DATA_W];
      default:  tx_nxt = 1'b1;
    endcase
  end

  // Both terms are flops: the state register and the registered tick.
  assign done = (state == S_STOP) && tick;

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, parity, tx_out, busy, done, par_err;
  logic [3:0] data;
  logic       in_valid1, in_ready1, parity1, tx_out1, busy1, done1, par_err1;
  logic [3:0] data1;

  always #5 clk = ~clk;

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .parity(parity), .tx_out(tx_out), .busy(busy),
    .done(done), .par_err(par_err)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .data(data1), .parity(parity1), .tx_out(tx_out1), .busy(busy1),
    .done(done1), .par_err(par_err1)
  );

  typedef struct packed {
    logic [6:0] frame;  // start bit in [6], stop bit in [0]
    logic       perr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Offer a frame at the current negedge; returns at the negedge after the accept.
  task automatic send(input logic [3:0] d, input logic p, input bit hold);
    int k;
    in_valid = 1'b1;
    data     = d;
    parity   = p;
    k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready never rose, got %b expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    chk("start_latency", {busy, tx_out}, 2'b10);
    data   = ~d;
    parity = ~p;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) begin
      n_checks++;
      $display("FAIL done_timeout: done got %b expected 1 within %0d cycles", done, bound);
    end
  endtask

  // Monitor: collects each 28-cycle frame from dut4 and checks it against the scoreboard.
  initial begin : monitor
    logic       prev_busy;
    logic [27:0] bits;
    logic [6:0] got;
    logic [3:0] nib;
    logic       done_ok, stable;
    bit         abort;
    exp_t       e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && prev_busy !== 1'b1 && rst === 1'b0) begin
        bits = '0; done_ok = 1'b1; abort = 1'b0;
        for (int i = 0; i < 28; i++) begin
          if (i > 0) @(negedge clk);
          if (busy !== 1'b1) begin
            abort = 1'b1;
            break;
          end
          bits[27-i] = tx_out;
          if (done !== (i == 27)) done_ok = 1'b0;
        end
        if (abort) begin
          prev_busy = busy;
          chk("abort_no_done", done_ok, 1'b1);
        end else begin
          prev_busy = 1'b1;
          stable = 1'b1;
          for (int s = 0; s < 7; s++) begin
            nib = bits[27-4*s -: 4];
            if (nib != 4'h0 && nib != 4'hF) stable = 1'b0;
            got[6-s] = nib[3];
          end
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_frame: got frame %b expected none", got);
          end else begin
            e = sb_q.pop_front();
            chk("frame", got, e.frame);
            chk("frame_bits_stable", stable, 1'b1);
            chk("done_only_last_cycle", done_ok, 1'b1);
            chk("par_err_held", par_err, e.perr);
          end
        end
      end else begin
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [6:0] exp7;
    rst = 1'b1;
    in_valid = 1'b1; data = 4'b1011; parity = 1'b1;
    in_valid1 = 1'b0; data1 = 4'b0000; parity1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_outputs", {tx_out, busy, done, par_err}, 4'b1000);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {tx_out, in_ready, busy, done, par_err}, 5'b11000);
    end

    // Good frame
    sb_q.push_back('{frame: 7'b0101111, perr: 1'b0});
    send(4'b1011, 1'b1, 1'b0);
    chk("good_par_err", par_err, 1'b0);
    wait_done(40);
    @(negedge clk);
    chk("post_frame_idle", {tx_out, busy, in_ready}, 3'b101);

    // Bad parity, then a good frame clears par_err
    sb_q.push_back('{frame: 7'b0101101, perr: 1'b1});
    send(4'b1011, 1'b0, 1'b0);
    chk("bad_par_err_next_cycle", par_err, 1'b1);
    wait_done(40);
    @(negedge clk);
    sb_q.push_back('{frame: 7'b0000001, perr: 1'b0});
    send(4'b0000, 1'b0, 1'b0);
    chk("par_err_cleared", par_err, 1'b0);
    wait_done(40);
    @(negedge clk);

    // Back-to-back with in_valid held high
    sb_q.push_back('{frame: 7'b0111101, perr: 1'b0});
    sb_q.push_back('{frame: 7'b0000111, perr: 1'b0});
    send(4'b1111, 1'b0, 1'b1);
    data = 4'b0001; parity = 1'b1;
    repeat (10) @(negedge clk);
    chk("midframe_in_ready_low", {in_ready, busy}, 2'b01);
    wait_done(40);
    @(negedge clk);
    chk("b2b_gap_idle", {tx_out, busy, in_ready}, 3'b101);
    @(negedge clk);
    chk("b2b_second_start", {busy, tx_out}, 2'b10);
    in_valid = 1'b0;
    wait_done(40);
    @(negedge clk);

    // Reset during data bit c (c=0 for 1100)
    send(4'b1100, 1'b0, 1'b0);
    repeat (13) @(negedge clk);
    chk("pre_reset_bit_c", {busy, tx_out}, 2'b10);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_frame", {tx_out, busy, done}, 3'b100);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_reset_quiet", {tx_out, busy, done}, 3'b100);
    end

    // CLKS_PER_BIT=1 instance
    exp7 = 7'b0011001;
    in_valid1 = 1'b1; data1 = 4'b0110; parity1 = 1'b0;
    chk("cpb1_in_ready", in_ready1, 1'b1);
    @(negedge clk);
    in_valid1 = 1'b0; data1 = 4'b1001; parity1 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      chk("cpb1_tx", tx_out1, exp7[6-c]);
      chk("cpb1_done", done1, (c == 6));
    end
    chk("cpb1_par_err", par_err1, 1'b0);
    @(negedge clk);
    chk("cpb1_idle_after", {tx_out1, busy1}, 2'b10);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
